// File: rtl/dense_layer_sequencer.sv
// Sequencer for a dense output layer: buffers features, streams weights through one MAC, tracks argmax.
// Optional: define DENSE_SEQ_SAT_EN to saturate every accumulate step instead of wrapping.
module dense_layer_sequencer #(
    parameter int N_IN   = 100,
    parameter int N_OUT  = 2,
    parameter int IN_W   = 8,
    parameter int W_W    = 16,
    parameter int ACC_W  = 32,
    parameter int ADDR_W = 8,
    parameter int CLS_W  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    busy,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [IN_W-1:0]         in_data,
    output logic                    w_rd_en,
    output logic [ADDR_W-1:0]       w_addr,
    input  logic [W_W-1:0]          w_rd_data,
    output logic                    done,
    output logic [CLS_W-1:0]        class_idx,
    output logic                    class_valid,
    output logic signed [ACC_W-1:0] score_max
);

    localparam int CNT_W  = $clog2(N_IN + 1);
    localparam int PROD_W = IN_W + 1 + W_W;
    localparam int SUM_W  = ((ACC_W > PROD_W) ? ACC_W : PROD_W) + 1;

`ifdef DENSE_SEQ_SAT_EN
    localparam logic signed [SUM_W-1:0] SAT_HI = {{(SUM_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SAT_LO = {{(SUM_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};
`endif

    typedef enum logic [2:0] {IDLE, LOAD, BIAS, MAC, DRAIN, DONE} state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        i_q;
    logic [CLS_W-1:0]        j_q;
    logic [ADDR_W-1:0]       addr_q;
    logic [IN_W-1:0]         feat_q [N_IN];
    logic signed [ACC_W-1:0] acc_q;

    logic signed [IN_W:0]    x_s;
    logic signed [PROD_W-1:0] prod;
    logic signed [SUM_W-1:0] sum_w;
    logic signed [ACC_W-1:0] acc_step;
    logic signed [ACC_W-1:0] bias_fit;

    // Brings a wide intermediate back to accumulator width (clamp or wrap).
    function automatic logic signed [ACC_W-1:0] fit_acc(input logic signed [SUM_W-1:0] v);
`ifdef DENSE_SEQ_SAT_EN
        if (v > SAT_HI)
            return ACC_W'(SAT_HI);
        else if (v < SAT_LO)
            return ACC_W'(SAT_LO);
        else
            return ACC_W'(v);
`else
        return ACC_W'(v);
`endif
    endfunction

    // i_q runs one ahead of the feature paired with the returning ROM word.
    always_comb begin
        x_s      = {1'b0, feat_q[i_q - CNT_W'(1)]};
        prod     = PROD_W'(x_s) * PROD_W'(signed'(w_rd_data));
        sum_w    = SUM_W'(acc_q) + SUM_W'(prod);
        acc_step = fit_acc(sum_w);
        bias_fit = fit_acc(SUM_W'(signed'(w_rd_data)));
    end

    always_comb begin
        state_d  = state_q;
        busy     = (state_q != IDLE);
        in_ready = 1'b0;
        w_rd_en  = 1'b0;
        w_addr   = addr_q;
        done     = 1'b0;
        case (state_q)
            IDLE:  if (start) state_d = LOAD;
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid && int'(i_q) == N_IN - 1) state_d = BIAS;
            end
            BIAS: begin
                w_rd_en = 1'b1;
                w_addr  = ADDR_W'(N_IN * N_OUT + int'(j_q));
                state_d = MAC;
            end
            MAC: begin
                w_rd_en = 1'b1;
                w_addr  = ADDR_W'(int'(j_q) * N_IN + int'(i_q));
                if (int'(i_q) == N_IN - 1) state_d = DRAIN;
            end
            DRAIN: state_d = (int'(j_q) == N_OUT - 1) ? DONE : BIAS;
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            i_q         <= '0;
            j_q         <= '0;
            addr_q      <= '0;
            score_max   <= '0;
            class_idx   <= '0;
            class_valid <= 1'b0;
        end else begin
            state_q <= state_d;
            if (w_rd_en) addr_q <= w_addr;
            case (state_q)
                IDLE: if (start) begin
                    class_valid <= 1'b0;
                    i_q         <= '0;
                end
                LOAD: if (in_valid) begin
                    i_q <= (int'(i_q) == N_IN - 1) ? '0 : i_q + CNT_W'(1);
                    j_q <= '0;
                end
                BIAS: i_q <= '0;
                MAC:  i_q <= i_q + CNT_W'(1);
                DRAIN: begin
                    // Strict compare keeps the lower index on ties.
                    if (j_q == '0 || acc_step > score_max) begin
                        score_max <= acc_step;
                        class_idx <= j_q;
                    end
                    if (int'(j_q) != N_OUT - 1) j_q <= j_q + CLS_W'(1);
                end
                DONE: class_valid <= 1'b1;
                default: ;
            endcase
        end
    end

    // Datapath storage carries no reset.
    always_ff @(posedge clk) begin
        if (state_q == LOAD && in_valid) feat_q[i_q] <= in_data;
        if (state_q == MAC) acc_q <= (i_q == '0) ? bias_fit : acc_step;
    end

endmodule

// File: tb/tb_dense_layer_sequencer.sv
// Directed bench for dense_layer_sequencer (ACC_W=24) with a synchronous ROM model.
module tb_dense_layer_sequencer;

    localparam int N_IN   = 100;
    localparam int N_OUT  = 2;
    localparam int IN_W   = 8;
    localparam int W_W    = 16;
    localparam int ACC_W  = 24;
    localparam int ADDR_W = 8;
    localparam int CLS_W  = 1;

    logic                    clk;
    logic                    rst;
    logic                    start;
    logic                    busy;
    logic                    in_valid;
    logic                    in_ready;
    logic [IN_W-1:0]         in_data;
    logic                    w_rd_en;
    logic [ADDR_W-1:0]       w_addr;
    logic [W_W-1:0]          w_rd_data;
    logic                    done;
    logic [CLS_W-1:0]        class_idx;
    logic                    class_valid;
    logic signed [ACC_W-1:0] score_max;

    logic [W_W-1:0] rom [256];
    int vectors;
    int miscompares;
    int lat;
    int accepts;

    dense_layer_sequencer #(
        .N_IN(N_IN), .N_OUT(N_OUT), .IN_W(IN_W), .W_W(W_W),
        .ACC_W(ACC_W), .ADDR_W(ADDR_W), .CLS_W(CLS_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .w_rd_en(w_rd_en), .w_addr(w_addr), .w_rd_data(w_rd_data),
        .done(done), .class_idx(class_idx), .class_valid(class_valid),
        .score_max(score_max)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (w_rd_en) w_rd_data <= rom[w_addr];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic set_rom(input logic [W_W-1:0] w0, input logic [W_W-1:0] w1,
                           input logic [W_W-1:0] b0, input logic [W_W-1:0] b1);
        for (int i = 0; i < 256; i++) rom[i] = '0;
        for (int i = 0; i < N_IN; i++) begin
            rom[i]        = w0;
            rom[N_IN + i] = w1;
        end
        rom[N_IN * N_OUT]     = b0;
        rom[N_IN * N_OUT + 1] = b1;
    endtask

    // One inference; lat = edges from last accept until done is seen high.
    task automatic do_run(input logic [IN_W-1:0] x, input bit noisy, output int lat_o, output int acc_o);
        int guard;
        acc_o = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("load_in_ready", in_ready, 1);
        check("start_clears_class_valid", class_valid, 0);
        guard = 0;
        while (acc_o < N_IN && guard < 2000) begin
            in_valid = noisy ? ($urandom_range(0, 2) != 0) : 1'b1;
            in_data  = x;
            if (in_valid && in_ready) acc_o++;
            @(posedge clk); #1;
            guard++;
        end
        in_valid = 1'b0;
        check("bias_rd_en", w_rd_en, 1);
        check("bias_addr", w_addr, N_IN * N_OUT);
        lat_o = 0;
        while (lat_o < 1000) begin
            if (noisy) begin
                in_valid = 1'b1;
                start    = (lat_o == 50);
            end
            if (in_valid && in_ready) acc_o++;
            @(posedge clk); #1;
            lat_o++;
            if (done) break;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        check("done_rd_en_low", w_rd_en, 0);
        check("done_addr_held", w_addr, N_IN * N_OUT - 1);
        @(posedge clk); #1;
        check("done_single_pulse", done, 0);
        check("idle_after_done", busy, 0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        set_rom(16'd1, 16'd2, 16'd0, 16'd0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_w_rd_en", w_rd_en, 0);
        check("rst_w_addr", w_addr, 0);
        check("rst_done", done, 0);
        check("rst_class_valid", class_valid, 0);
        check("rst_class_idx", class_idx, 0);
        check("rst_score_max", score_max, 0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("idle_stays_without_start", busy, 0);

        do_run(8'd1, 1'b0, lat, accepts);
        check("nom_latency", lat, 204);
        check("nom_accepts", accepts, 100);
        check("nom_class", class_idx, 1);
        check("nom_score", score_max, 200);
        check("nom_class_valid", class_valid, 1);

        set_rom(16'd3, 16'd3, 16'd7, 16'd7);
        do_run(8'h10, 1'b0, lat, accepts);
        check("tie_class", class_idx, 0);
        check("tie_score", score_max, 4807);

        set_rom(16'hFFFF, 16'h0000, 16'd5, 16'hFFFD);
        do_run(8'h10, 1'b0, lat, accepts);
        check("signed_class", class_idx, 1);
        check("signed_score", score_max, -3);

        set_rom(16'd1, 16'd2, 16'd0, 16'd0);
        do_run(8'd1, 1'b1, lat, accepts);
        check("hs_latency", lat, 204);
        check("hs_accepts", accepts, 100);
        check("hs_class", class_idx, 1);
        check("hs_score", score_max, 200);

        set_rom(16'h7FFF, 16'hFF38, 16'd0, 16'd0);
        do_run(8'hFF, 1'b0, lat, accepts);
        check("sat_class", class_idx, 0);
`ifdef DENSE_SEQ_SAT_EN
        check("sat_score", score_max, 8388607);
`else
        check("wrap_score", score_max, -3302300);
`endif

        // Abort mid-load; outputs must fall without a clock edge.
        set_rom(16'd1, 16'd2, 16'd0, 16'd0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'd1;
        repeat (10) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_in_ready", in_ready, 0);
        check("abort_done", done, 0);
        check("abort_class_valid", class_valid, 0);
        check("abort_class_idx", class_idx, 0);
        check("abort_score_max", score_max, 0);
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("abort_idle", busy, 0);

        do_run(8'd1, 1'b0, lat, accepts);
        check("recover_latency", lat, 204);
        check("recover_score", score_max, 200);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
